floo_mcast_fork_ctrl: RTL and testbench

- Output-side fork controller placed after route selection in a router input path.
- Takes one flit plus a multi-hot route mask and replicates the flit's valid to every selected output port.
- Tracks which outputs have already accepted the flit and releases the input only when all selected outputs have taken it.
- Locks the route mask for the whole wormhole packet, from the first flit through the `hdr.last` flit.

---
 rtl/floo_mcast_fork_ctrl.sv | 141 ++++++++++++++
 tb/tb_floo_mcast_fork_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/floo_mcast_fork_ctrl.sv
// ---------------------------------------------------------------------------
// floo_mcast_fork_ctrl
//
// Purpose:
//   Output-side fork controller that sits after route selection. It copies
//   one upstream flit's valid to every output named in a multi-hot route
//   mask. It remembers which outputs have already taken the flit and releases
//   the upstream side only when every selected output has accepted it. The
//   route mask is held for a whole wormhole packet, from the first flit up to
//   and including the flit with hdr.last set.
//
// Optional feature:
//   FLOO_MCAST_FORK_STATS_EN - adds stat_mcast_cnt_o. This saturating counter
//   counts consumed flits that went to two or more outputs.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   valid_i          upstream flit valid
//   ready_o          flit accepted by all selected outputs
//   channel_i        upstream flit (must contain hdr.last)
//   route_sel_i      route mask (one-hot unicast, multi-hot multicast)
//   valid_o          per-output valid
//   ready_i          per-output ready
//   channel_o        flit broadcast to all outputs (combinational copy)
//   stat_mcast_cnt_o multicast flit counter (only with the stats macro)
//   busy_o           flit partially delivered or packet locked
//   err_o            one-cycle pulse after an empty mask was consumed
// ---------------------------------------------------------------------------

package floo_mcast_fork_ctrl_pkg;

  typedef struct packed {
    logic       last;
    logic [3:0] dst;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [31:0] data;
  } flit_t;

endpackage

module floo_mcast_fork_ctrl #(
  parameter int unsigned NumRoutes = 5,
  parameter type         flit_t    = floo_mcast_fork_ctrl_pkg::flit_t,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                channel_i,
  input  logic [NumRoutes-1:0] route_sel_i,
  output logic [NumRoutes-1:0] valid_o,
  input  logic [NumRoutes-1:0] ready_i,
  output flit_t                channel_o,
`ifdef FLOO_MCAST_FORK_STATS_EN
  output logic [CntWidth-1:0]  stat_mcast_cnt_o,
`endif
  output logic                 busy_o,
  output logic                 err_o
);

  logic [NumRoutes-1:0] r_sent;
  logic                 r_locked;
  logic [NumRoutes-1:0] r_sel;
  logic                 r_err;

  logic [NumRoutes-1:0] w_sel;
  logic                 w_done;
  logic                 w_consume;

  // Inside a packet the latched mask wins, so body flits follow the head.
  assign w_sel = r_locked ? r_sel : route_sel_i;

  // An output counts as finished if it was never selected, has already taken
  // the flit, or is taking it now.
  assign w_done    = &(~w_sel | r_sent | ready_i);
  assign w_consume = valid_i & w_done;

  assign valid_o   = {NumRoutes{valid_i}} & w_sel & ~r_sent;
  assign ready_o   = w_consume;
  assign channel_o = channel_i;
  assign busy_o    = r_locked | (|r_sent);
  assign err_o     = r_err;

  // If valid_i drops mid-flit, every register keeps its value. A consumed
  // flit clears the delivery record. A non-last flit locks the mask, which is
  // captured only on the head flit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sent   <= '0;
      r_locked <= 1'b0;
      r_sel    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= valid_i & ~(|w_sel);
      if (valid_i) begin
        if (w_done) begin
          r_sent <= '0;
          if (!channel_i.hdr.last) begin
            r_locked <= 1'b1;
            if (!r_locked) begin
              r_sel <= w_sel;
            end
          end else begin
            r_locked <= 1'b0;
          end
        end else begin
          r_sent <= r_sent | (valid_o & ready_i);
        end
      end
    end
  end

`ifdef FLOO_MCAST_FORK_STATS_EN
  logic [CntWidth-1:0] r_mcastCnt;
  logic                w_multi;

  // Clearing the lowest set bit leaves a non-zero value only when two or
  // more bits were set.
  assign w_multi          = |(w_sel & (w_sel - NumRoutes'(1)));
  assign stat_mcast_cnt_o = r_mcastCnt;

  // The counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcastCnt <= '0;
    end else if (w_consume && w_multi && (r_mcastCnt != '1)) begin
      r_mcastCnt <= r_mcastCnt + CntWidth'(1);
    end
  end
`else
  // The counter width matters only when the statistics counter is built.
  if (CntWidth == 0) begin : g_noCnt
  end
`endif

endmodule

// File: tb/tb_floo_mcast_fork_ctrl.sv
// Testbench for floo_mcast_fork_ctrl. A table of directed vectors is applied
// back to back, so controller state carries over from one vector to the next.
// Hand-written sequences cover asynchronous reset mid-flit and, when
// FLOO_MCAST_FORK_STATS_EN is defined, the saturating counter.
module tb_floo_mcast_fork_ctrl;

  import floo_mcast_fork_ctrl_pkg::*;

  logic       clk_i;
  logic       rst_ni;
  logic       valid_i;
  logic       ready_o;
  flit_t      channel_i;
  logic [4:0] route_sel_i;
  logic [4:0] valid_o;
  logic [4:0] ready_i;
  flit_t      channel_o;
  logic       busy_o;
  logic       err_o;
`ifdef FLOO_MCAST_FORK_STATS_EN
  logic [1:0] stat_mcast_cnt_o;
`endif

  int errors;
  int checks;

  floo_mcast_fork_ctrl #(
    .NumRoutes (5),
    .flit_t    (flit_t),
    .CntWidth  (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .channel_i   (channel_i),
    .route_sel_i (route_sel_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .channel_o   (channel_o),
`ifdef FLOO_MCAST_FORK_STATS_EN
    .stat_mcast_cnt_o (stat_mcast_cnt_o),
`endif
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // 10 time-unit clock; rising edges fall at 5, 15, 25, ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       valid;
    logic [4:0] sel;
    logic       last;
    logic [4:0] rdy;
    logic [4:0] expValid;
    logic       expReady;
    logic       expBusy;
    logic       expErr;
  } vec_t;

  localparam int NumVecs = 15;
  vec_t vecs [NumVecs];

  // Compares one observed value with its expected value and counts the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives the upstream and downstream inputs.
  task automatic applyStimulus(input logic v, input logic [4:0] sel, input logic last, input logic [4:0] rdy);
    valid_i            = v;
    route_sel_i        = sel;
    channel_i.hdr.last = last;
    ready_i            = rdy;
  endtask

  initial begin
    logic [31:0] payload;
    errors  = 0;
    checks  = 0;
    payload = 32'hCAFE_0123;

    // Columns: valid, sel, last, rdy | expValid, expReady, expBusy, expErr.
    // The busy and err columns are the values seen after the clock edge.
    // Unicast 3-flit packet
    vecs[0]  = '{1'b1, 5'b00100, 1'b0, 5'b11111, 5'b00100, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 5'b00100, 1'b0, 5'b11111, 5'b00100, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 5'b00100, 1'b1, 5'b11111, 5'b00100, 1'b1, 1'b0, 1'b0};
    // Multicast partial acceptance
    vecs[3]  = '{1'b1, 5'b11010, 1'b1, 5'b01010, 5'b11010, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'b11010, 1'b1, 5'b10000, 5'b10000, 1'b1, 1'b0, 1'b0};
    // Packet lock, then a new packet right after the last flit
    vecs[5]  = '{1'b1, 5'b00110, 1'b0, 5'b11111, 5'b00110, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'b00001, 1'b0, 5'b11111, 5'b00110, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'b00001, 1'b1, 5'b11111, 5'b00110, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'b00001, 1'b1, 5'b11111, 5'b00001, 1'b1, 1'b0, 1'b0};
    // Empty mask, then idle so err drops again
    vecs[9]  = '{1'b1, 5'b00000, 1'b1, 5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0};
    // Locked packet: the final outstanding ready arrives with the last flit
    vecs[11] = '{1'b1, 5'b01100, 1'b0, 5'b11111, 5'b01100, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'b00000, 1'b1, 5'b00100, 5'b01100, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'b00000, 1'b1, 5'b01000, 5'b01000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'b00010, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_ni             = 1'b0;
    channel_i.data     = payload;
    channel_i.hdr.dst  = 4'h3;
    applyStimulus(1'b0, 5'b00000, 1'b0, 5'b00000);
    #12;
    checkOutput("reset valid_o", 32'(valid_o), 32'h0);
    checkOutput("reset ready_o", 32'(ready_o), 32'h0);
    checkOutput("reset busy_o", 32'(busy_o), 32'h0);
    checkOutput("reset err_o", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vector table
    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i].valid, vecs[i].sel, vecs[i].last, vecs[i].rdy);
      #1;
      checkOutput($sformatf("v%0d valid_o", i), 32'(valid_o), 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d ready_o", i), 32'(ready_o), 32'(vecs[i].expReady));
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("v%0d busy_o", i), 32'(busy_o), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d err_o", i), 32'(err_o), 32'(vecs[i].expErr));
    end
    checkOutput("channel_o copy", channel_o.data, payload);

    // Reset mid-flit: lock a packet, partially deliver flit 2, then reset
    @(negedge clk_i);
    applyStimulus(1'b1, 5'b00011, 1'b0, 5'b11111);
    @(negedge clk_i);
    applyStimulus(1'b1, 5'b00011, 1'b1, 5'b00001);
    @(posedge clk_i);
    #1;
    checkOutput("partial valid_o", 32'(valid_o), 32'h02);
    checkOutput("partial busy_o", 32'(busy_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async rst busy_o", 32'(busy_o), 32'h0);
    checkOutput("async rst valid_o", 32'(valid_o), 32'h03);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1'b1, 5'b10000, 1'b1, 5'b00000);
    #1;
    checkOutput("unlocked valid_o", 32'(valid_o), 32'h10);
    applyStimulus(1'b1, 5'b00011, 1'b1, 5'b11111);
    #1;
    checkOutput("re-present valid_o", 32'(valid_o), 32'h03);
    checkOutput("re-present ready_o", 32'(ready_o), 32'h1);
    @(posedge clk_i);
    #1;
    checkOutput("re-present busy_o", 32'(busy_o), 32'h0);

`ifdef FLOO_MCAST_FORK_STATS_EN
    // Saturating multicast counter, CntWidth = 2
    @(negedge clk_i);
    rst_ni = 1'b0;
    applyStimulus(1'b0, 5'b00000, 1'b1, 5'b11111);
    #1;
    checkOutput("stat reset", 32'(stat_mcast_cnt_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] expCnt;
      expCnt = (k < 3) ? 2'(k + 1) : 2'd3;
      @(negedge clk_i);
      applyStimulus(1'b1, 5'b00011, 1'b1, 5'b11111);
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("stat cnt %0d", k), 32'(stat_mcast_cnt_o), 32'(expCnt));
    end
    @(negedge clk_i);
    applyStimulus(1'b1, 5'b00100, 1'b1, 5'b11111);
    @(posedge clk_i);
    #1;
    checkOutput("stat unicast", 32'(stat_mcast_cnt_o), 32'h3);
`endif

    @(negedge clk_i);
    applyStimulus(1'b0, 5'b00000, 1'b0, 5'b00000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
